// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types plus the operand-entry state enum
//               and small helpers used by the ALU entry controller.
//               Exports: word_t (32-bit datapath word), aluop_t (4-bit
//               opcode), entry_state_t (ENTER_A/ENTER_B/ENTER_OP/SHOW),
//               sext_sw() and state_onehot().
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    ENTER_OP = 2'd2,
    SHOW     = 2'd3
  } entry_state_t;

  // Switch bank layout: [15:0] magnitude bits, [16] sign. The sign bit is
  // replicated over the upper half of the word.
  function automatic word_t sext_sw(input logic [16:0] sw);
    return {{16{sw[16]}}, sw[15:0]};
  endfunction

  // LED pattern for a given entry state: bit n lit for state n.
  function automatic logic [3:0] state_onehot(input entry_state_t st);
    logic [3:0] led;
    led = 4'b0000;
    led[st] = 1'b1;
    return led;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : One pushbutton channel: two-flop synchronizer, saturating
//               debounce counter and press-edge detector.
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   key_n_i in   raw active-low key, asynchronous to clk_i
//   press_o out  one-cycle pulse in the cycle the debounced level becomes
//                "pressed"
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q,  sync_q;
  logic             level_q, level_d;   // debounced level, 1 = released
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // The counter is cleared on every flip and every agreeing sample, so it
  // stops at CNT_LAST and can never wrap into a false acceptance.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        cnt_d   = '0;
        if (!sync_q) begin
          press_d = armed_q;
        end else begin
          armed_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      // Synchronizer resets to "pressed", so a key held through reset never
      // shows a released sample and stays disarmed until a debounced release.
      if (level_q && sync_q) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= key_n_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/alu_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_entry_ctrl
// Description : Pushbutton/switch front end that captures two signed 16-bit
//               operands and an ALU opcode in sequence.
//   CLOCK_50  in   clock
//   RST       in   synchronous active-high reset
//   KEY[3:0]  in   raw active-low keys; KEY[0] advance, KEY[1] abort
//   SW[17:0]  in   raw switches; [15:0] value, [16] sign, [3:0] opcode
//   portA     out  captured operand A
//   portB     out  captured operand B
//   ALUOP     out  captured opcode
//   valid     out  A, B and ALUOP form a committed set
//   state_led out  one-hot entry state
// Revision    : 1.0 - initial release
// ============================================================================
module alu_entry_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output word_t       portA,
  output word_t       portB,
  output aluop_t      ALUOP,
  output logic        valid,
  output logic [3:0]  state_led
);

  logic [17:0]  sw_meta_q, sw_sync_q;
  logic [3:0]   press;
  entry_state_t state_q;
  logic [2:0]   unused_bits;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk_i  (CLOCK_50),
        .rst_i  (RST),
        .key_n_i(KEY[i]),
        .press_o(press[i])
      );
    end
  endgenerate

  // KEY[3:2] are debounced but have no function; SW[17] is unassigned.
  assign unused_bits = {press[3:2], sw_sync_q[17]};

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q   <= ENTER_A;
      portA     <= '0;
      portB     <= '0;
      ALUOP     <= '0;
      valid     <= 1'b0;
      state_led <= state_onehot(ENTER_A);
    end else if (press[1]) begin
      // Abort outranks a coincident advance; captured values are kept.
      state_q   <= ENTER_A;
      valid     <= 1'b0;
      state_led <= state_onehot(ENTER_A);
    end else if (press[0]) begin
      unique case (state_q)
        ENTER_A: begin
          portA     <= sext_sw(sw_sync_q[16:0]);
          state_q   <= ENTER_B;
          state_led <= state_onehot(ENTER_B);
        end
        ENTER_B: begin
          portB     <= sext_sw(sw_sync_q[16:0]);
          state_q   <= ENTER_OP;
          state_led <= state_onehot(ENTER_OP);
        end
        ENTER_OP: begin
          ALUOP     <= sw_sync_q[3:0];
          valid     <= 1'b1;
          state_q   <= SHOW;
          state_led <= state_onehot(SHOW);
        end
        SHOW: begin
          valid     <= 1'b0;
          state_q   <= ENTER_A;
          state_led <= state_onehot(ENTER_A);
        end
        default: begin
          state_q   <= ENTER_A;
          state_led <= state_onehot(ENTER_A);
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_entry_ctrl
// Description : Directed self-checking bench for alu_entry_ctrl with a
//               four-cycle debounce window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_entry_ctrl;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic [17:0] sw;
  word_t       pa, pb;
  aluop_t      op;
  logic        v;
  logic [3:0]  led;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .KEY      (key),
    .SW       (sw),
    .portA    (pa),
    .portB    (pb),
    .ALUOP    (op),
    .valid    (v),
    .state_led(led)
  );

  typedef struct {
    logic [17:0] sw;
    logic [3:0]  keys;   // keys pressed (1 = press)
    word_t       a;
    word_t       b;
    aluop_t      op;
    logic        v;
    logic [3:0]  led;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input word_t ea, input word_t eb,
                           input aluop_t eo, input logic ev, input logic [3:0] el);
    chk($sformatf("%s portA", tag), pa, ea);
    chk($sformatf("%s portB", tag), pb, eb);
    chk($sformatf("%s ALUOP", tag), 32'(op), 32'(eo));
    chk($sformatf("%s valid", tag), 32'(v), 32'(ev));
    chk($sformatf("%s state_led", tag), 32'(led), 32'(el));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    key = ~mask;
    cycles(10);
    key = 4'hF;
    cycles(10);
  endtask

  initial begin
    vecs[0]  = '{18'h10005, 4'b0001, 32'hFFFF0005, 32'h00000000, 4'h0, 1'b0, 4'b0010};
    vecs[1]  = '{18'h00003, 4'b0001, 32'hFFFF0005, 32'h00000003, 4'h0, 1'b0, 4'b0100};
    vecs[2]  = '{18'h00002, 4'b0001, 32'hFFFF0005, 32'h00000003, 4'h2, 1'b1, 4'b1000};
    vecs[3]  = '{18'h07FFF, 4'b0001, 32'hFFFF0005, 32'h00000003, 4'h2, 1'b0, 4'b0001};
    vecs[4]  = '{18'h18000, 4'b0001, 32'hFFFF8000, 32'h00000003, 4'h2, 1'b0, 4'b0010};
    vecs[5]  = '{18'h0FFFF, 4'b0010, 32'hFFFF8000, 32'h00000003, 4'h2, 1'b0, 4'b0001};
    vecs[6]  = '{18'h0FFFF, 4'b0001, 32'h0000FFFF, 32'h00000003, 4'h2, 1'b0, 4'b0010};
    vecs[7]  = '{18'h10001, 4'b0001, 32'h0000FFFF, 32'hFFFF0001, 4'h2, 1'b0, 4'b0100};
    vecs[8]  = '{18'h0000F, 4'b0011, 32'h0000FFFF, 32'hFFFF0001, 4'h2, 1'b0, 4'b0001};
    vecs[9]  = '{18'h20011, 4'b0001, 32'h00000011, 32'hFFFF0001, 4'h2, 1'b0, 4'b0010};
    vecs[10] = '{18'h1FFFE, 4'b0001, 32'h00000011, 32'hFFFFFFFE, 4'h2, 1'b0, 4'b0100};
    vecs[11] = '{18'h00007, 4'b0001, 32'h00000011, 32'hFFFFFFFE, 4'h7, 1'b1, 4'b1000};

    rst = 1'b1;
    key = 4'hF;
    sw  = 18'h10005;
    cycles(3);
    check_all("reset", 32'h0, 32'h0, 4'h0, 1'b0, 4'b0001);
    rst = 1'b0;
    cycles(10);
    chk("idle led", 32'(led), 32'h1);

    // Bounce shorter than the window: no change.
    key[0] = 1'b0; cycles(3);
    key[0] = 1'b1; cycles(1);
    key[0] = 1'b0; cycles(3);
    key[0] = 1'b1; cycles(10);
    chk("bounce led", 32'(led), 32'h1);

    // Clean 5-cycle press: output changes on the 7th edge after driving.
    key[0] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 5) key[0] = 1'b1;
      if (c == 6) chk("latency before", 32'(led), 32'h1);
      if (c == 7) begin
        chk("latency after led", 32'(led), 32'h2);
        chk("latency after portA", pa, 32'hFFFF0005);
      end
    end
    cycles(10);

    press(4'b0010);
    chk("abort led", 32'(led), 32'h1);

    // Long hold yields one advance only.
    sw  = 18'h00009;
    key = 4'hE;
    cycles(100);
    chk("hold during led", 32'(led), 32'h2);
    key = 4'hF;
    cycles(10);
    chk("hold after led", 32'(led), 32'h2);
    chk("hold portA", pa, 32'h00000009);

    // Reset in ENTER_B with KEY0 held.
    key = 4'hE;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    check_all("rst held", 32'h0, 32'h0, 4'h0, 1'b0, 4'b0001);
    key = 4'hF;
    cycles(10);
    chk("rst released led", 32'(led), 32'h1);
    press(4'b0001);
    chk("rst repress led", 32'(led), 32'h2);
    chk("rst repress portA", pa, 32'h00000009);

    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(10);

    for (int i = 0; i < 12; i++) begin
      sw = vecs[i].sw;
      cycles(2);
      press(vecs[i].keys);
      check_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].v, vecs[i].led);
    end

    // In SHOW, switch activity alone must not disturb any output.
    for (int i = 0; i < 60; i++) begin
      sw = 18'($urandom);
      @(negedge clk);
      if (i % 20 == 19)
        check_all($sformatf("show sw%0d", i), 32'h00000011, 32'hFFFFFFFE, 4'h7, 1'b1, 4'b1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
